mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide unit controller for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers.
- Sequences a fixed-latency busy window and raises the D-stage stall when the instruction in D uses the MDU while it is occupied.

---
 rtl/mdu_ctrl.sv | 133 +++++++++++++
 tb/tb_mdu_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// HI/LO owner and multi-cycle mult/div sequencer for the E stage; results are computed at accept
// and committed when the fixed-latency busy window expires, with a D-stage stall while occupied.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_allmudi,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     shadow_hi, shadow_lo;
    logic            suppress_q;
    logic            commit;

    logic            op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic            op_md, op_any, accept, accept_md;

    assign op_mult  = (op == 3'd1);
    assign op_multu = (op == 3'd2);
    assign op_div   = (op == 3'd3);
    assign op_divu  = (op == 3'd4);
    assign op_mthi  = (op == 3'd5);
    assign op_mtlo  = (op == 3'd6);
    assign op_md    = op_mult | op_multu | op_div | op_divu;
    assign op_any   = op_md | op_mthi | op_mtlo;

    assign busy      = (count_q != '0);
    assign accept    = start & ~busy & op_any;
    assign accept_md = accept & op_md;
    assign stall     = d_allmudi & (busy | (start & op_md));

    // Products: 64-bit signed and unsigned.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    assign prod_s = 64'($signed(rs_val)) * 64'($signed(rt_val));
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Division on magnitudes, then sign fix-up: quotient truncates toward zero,
    // remainder follows the dividend.
    logic        neg_a, neg_b, div_zero;
    logic [31:0] abs_a, abs_b, safe_b, uq, ur, quo, rem;
    assign neg_a    = op_div & rs_val[31];
    assign neg_b    = op_div & rt_val[31];
    assign abs_a    = neg_a ? (32'd0 - rs_val) : rs_val;
    assign abs_b    = neg_b ? (32'd0 - rt_val) : rt_val;
    assign div_zero = (rt_val == 32'd0);
    assign safe_b   = div_zero ? 32'd1 : abs_b;
    assign uq       = abs_a / safe_b;
    assign ur       = abs_a % safe_b;
    assign quo      = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    assign rem      = neg_a ? (32'd0 - ur) : ur;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_md) begin
                    count_d = (op_div | op_divu) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = RUN;
                end
            end
            RUN: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shadow_hi  <= 32'd0;
            shadow_lo  <= 32'd0;
            suppress_q <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept_md) begin
                suppress_q <= (op_div | op_divu) & div_zero;
                if (op_mult) begin
                    shadow_hi <= prod_s[63:32];
                    shadow_lo <= prod_s[31:0];
                end else if (op_multu) begin
                    shadow_hi <= prod_u[63:32];
                    shadow_lo <= prod_u[31:0];
                end else begin
                    shadow_hi <= rem;
                    shadow_lo <= quo;
                end
            end
            // Commit and accept never share an edge: accept needs busy=0, commit needs busy=1.
            if (commit && !suppress_q) begin
                hi <= shadow_hi;
                lo <= shadow_lo;
            end else if (accept && op_mthi) begin
                hi <= rs_val;
            end else if (accept && op_mtlo) begin
                lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against a plain-arithmetic HI/LO reference model.
module tb_mdu_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        d_allmudi;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_allmudi (d_allmudi),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Never present start to a busy unit.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b1 && start === 1'b1) chk("proto_start_busy", 32'(busy), 32'd0);
    end

    function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el,
                                   output int lat, output bit wh, output bit wl);
        longint          sa, sb, q, r, ps;
        longint unsigned ua, ub, pu;
        logic [63:0]     p;
        eh = 32'd0; el = 32'd0; lat = 0; wh = 1'b0; wl = 1'b0;
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        case (o)
            3'd1: begin ps = sa * sb; p = ps; eh = p[63:32]; el = p[31:0]; wh = 1; wl = 1; lat = MULT_CYCLES; end
            3'd2: begin pu = ua * ub; p = pu; eh = p[63:32]; el = p[31:0]; wh = 1; wl = 1; lat = MULT_CYCLES; end
            3'd3: begin
                lat = DIV_CYCLES;
                if (b != 0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; wh = 1; wl = 1; end
            end
            3'd4: begin
                lat = DIV_CYCLES;
                if (b != 0) begin el = a / b; eh = a % b; wh = 1; wl = 1; end
            end
            3'd5: begin eh = a; wh = 1; end
            3'd6: begin el = a; wl = 1; end
            default: ;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge of the first idle cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit d);
        logic [31:0] eh, el;
        int          lat;
        bit          wh, wl;
        ref_op(o, a, b, eh, el, lat, wh, wl);
        start = 1'b1; op = o; rs_val = a; rt_val = b; d_allmudi = d;
        #1 chk("stall_accept", 32'(stall), 32'(d && (o inside {[3'd1:3'd4]})));
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < lat; i++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("stall_run", 32'(stall), 32'(d));
            chk("hi_hold", hi, m_hi);
            chk("lo_hold", lo, m_lo);
            @(negedge clk);
        end
        if (wh) m_hi = eh;
        if (wl) m_lo = el;
        chk("busy_done", 32'(busy), 32'd0);
        chk("stall_done", 32'(stall), 32'd0);
        chk("hi_result", hi, m_hi);
        chk("lo_result", lo, m_lo);
    endtask

    function automatic logic [31:0] pick(input int sel);
        logic [31:0] v;
        case (sel)
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; d_allmudi = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        chk("mult_hi_lit", hi, 32'hFFFF_FFFF);
        chk("mult_lo_lit", lo, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        chk("multu_hi_lit", hi, 32'h0000_0001);
        chk("multu_lo_lit", lo, 32'hFFFF_FFFE);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo_lit", lo, 32'hFFFF_FFFD);
        chk("div_hi_lit", hi, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd2, 1'b1);
        chk("divu_lo_lit", lo, 32'd3);
        chk("divu_hi_lit", hi, 32'd1);

        run_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
        run_op(3'd6, 32'h0000_5678, 32'd0, 1'b0);
        run_op(3'd3, 32'd5, 32'd0, 1'b1);
        chk("div0_hi_lit", hi, 32'h0000_1234);
        chk("div0_lo_lit", lo, 32'h0000_5678);

        run_op(3'd5, 32'hAAAA_0000, 32'd0, 1'b1);
        chk("mthi_lit", hi, 32'hAAAA_0000);
        run_op(3'd6, 32'h0000_5555, 32'd0, 1'b1);
        chk("mtlo_lit", lo, 32'h0000_5555);
        chk("mthi_kept", hi, 32'hAAAA_0000);
        run_op(3'd7, 32'h1111_1111, 32'd3, 1'b1);
        run_op(3'd0, 32'h2222_2222, 32'd3, 1'b1);

        // Reset in the middle of a divide: nothing may commit afterwards.
        start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; d_allmudi = 1'b0;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (6) @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk); reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_abort_busy", 32'(busy), 32'd0);
            chk("post_abort_hi", hi, 32'd0);
            chk("post_abort_lo", lo, 32'd0);
        end

        for (int n = 0; n < 80; n++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = pick($urandom_range(0, 7));
            b = pick($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0; d_allmudi = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_stall", 32'(stall), 32'd0);
            end
            run_op(o, a, b, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
